// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared state encoding, word types and parameter defaults for the fetch PC controller.
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] LINK_OFFSET      = 32'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register that parks a fetched word while ID is stalled.
module fetch_skid_buf
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  fetch_word_t word_in,
  output fetch_word_t word_out,
  output logic        valid
);

  fetch_word_t word_q, word_d;
  logic        valid_q, valid_d;

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (load) begin
      word_d  = word_in;
      valid_d = 1'b1;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the block order.
  // NOTE: the data word is reset as well, so a stray unload can never push X into ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_out = word_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner: sequences IM requests, feeds ID via valid/stall, applies delay-slot redirects.
// Optional misaligned-redirect trap is built when PC_ALIGN_CHECK_EN is defined.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic        exc_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;

  logic         slot_free, redirect_ok, word_enter, adel;
  logic         skid_load, skid_unload, skid_valid;
  logic [31:0]  nxt;
  fetch_word_t  skid_in, skid_out, enter_word;

  assign slot_free   = !if_valid_q || !stall_id;
  assign redirect_ok = redirect && !stall_id;
  assign nxt         = redirect_ok ? redirect_pc : (pend_q ? pend_pc_q : pc_q + INSTR_BYTES);
  assign skid_in     = '{pc: pc_q, instr: imem_rdata};

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .word_in  (skid_in),
    .word_out (skid_out),
    .valid    (skid_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    word_enter  = 1'b0;
    enter_word  = '0;
    adel        = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if (slot_free) begin
            word_enter = 1'b1;
            enter_word = skid_in;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (if_valid_q && !stall_id) begin
          if_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_id && skid_valid) begin
          word_enter  = 1'b1;
          enter_word  = skid_out;
          skid_unload = 1'b1;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The PC only moves when a word lands in ID, so the word in flight is always the delay slot.
    if (word_enter) begin
      if_valid_d = 1'b1;
      if_pc_d    = enter_word.pc;
      if_instr_d = enter_word.instr;
      pc_d       = nxt;
      pend_d     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if (nxt[1:0] != 2'b00) begin
        pc_d = EXC_VEC;
        adel = 1'b1;
      end
`endif
    end else if (redirect_ok) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_pc;
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  // The trap vector is only consumed by the alignment check.
  logic unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc8    = if_pc_q + LINK_OFFSET;
  assign exc_adel  = adel;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus a randomized delivered-stream model.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic        exc_adel;

  int total = 0;
  int bad   = 0;

  fetch_pc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc8      (if_pc8),
    .exc_adel    (exc_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IM model: acks only a live request, returning the word at the requested address.
  task automatic respond(input bit ack_en);
    imem_ack   = ack_en && imem_req;
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    stall_id    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RESET_PC); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    total++; if (if_pc8 !== 32'h8) begin bad++; $display("FAIL rst_pc8 got=%h exp=8", if_pc8); end
    total++; if (exc_adel !== 1'b0) begin bad++; $display("FAIL rst_adel got=%b exp=0", exc_adel); end
    reset = 1'b0;
    // Idle bubble: a stray ack with no request must be ignored.
    imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored got=%b exp=0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_pc = RESET_PC + 32'(i * 4);
      total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        bad++; $display("FAIL zw_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, exp_pc);
      end
      if (i > 0) begin
        total++; if (if_valid !== 1'b1 || if_pc !== exp_pc - 32'd4 || if_instr !== mem_word(exp_pc - 32'd4)) begin
          bad++; $display("FAIL zw_if%0d got=%b/%h/%h exp=1/%h", i, if_valid, if_pc, if_instr, exp_pc - 32'd4);
        end
        total++; if (if_pc8 !== exp_pc + 32'd4) begin bad++; $display("FAIL zw_pc8%0d got=%h exp=%h", i, if_pc8, exp_pc + 32'd4); end
      end
      respond(1'b1);
      tick();
    end
  endtask

  task automatic test_im_wait();
    do_reset();
    tick(); respond(1'b1);
    tick();
    total++; if (imem_addr !== 32'h3004 || if_valid !== 1'b1 || if_pc !== 32'h3000) begin
      bad++; $display("FAIL wait_start got=%h/%b/%h exp=3004/1/3000", imem_addr, if_valid, if_pc);
    end
    respond(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || if_valid !== 1'b0) begin
        bad++; $display("FAIL wait_hold%0d got=%b/%h/%b exp=1/3004/0", i, imem_req, imem_addr, if_valid);
      end
      respond(i == 2);
    end
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h3004 || if_instr !== mem_word(32'h3004) || imem_addr !== 32'h3008) begin
      bad++; $display("FAIL wait_done got=%b/%h/%h exp=1/3004/3008", if_valid, if_pc, imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    tick(); respond(1'b1);
    tick(); respond(1'b1);
    tick();
    total++; if (if_pc !== 32'h3004 || imem_addr !== 32'h3008) begin
      bad++; $display("FAIL stall_pre got=%h/%h exp=3004/3008", if_pc, imem_addr);
    end
    stall_id = 1'b1; respond(1'b1);
    tick(); respond(1'b1);
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h3004) begin
      bad++; $display("FAIL stall_hold got=%b/%b/%h exp=0/1/3004", imem_req, if_valid, if_pc);
    end
    tick();
    stall_id = 1'b0; respond(1'b1);
    total++; if (imem_req !== 1'b0 || if_pc !== 32'h3004) begin
      bad++; $display("FAIL stall_hold2 got=%b/%h exp=0/3004", imem_req, if_pc);
    end
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h3008 || if_instr !== mem_word(32'h3008)) begin
      bad++; $display("FAIL stall_release got=%b/%h/%h exp=1/3008/%h", if_valid, if_pc, if_instr, mem_word(32'h3008));
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300c) begin
      bad++; $display("FAIL stall_next got=%b/%h exp=1/300c", imem_req, imem_addr);
    end
  endtask

  // Brings a zero-wait stream up to the cycle where the word at 0x3010 sits in ID.
  task automatic reach_branch();
    do_reset();
    tick();
    repeat (5) begin respond(1'b1); tick(); end
    total++; if (if_pc !== 32'h3010 || imem_addr !== 32'h3014) begin
      bad++; $display("FAIL br_setup got=%h/%h exp=3010/3014", if_pc, imem_addr);
    end
  endtask

  task automatic test_branch();
    reach_branch();
    redirect = 1'b1; redirect_pc = 32'h3100; respond(1'b1);
    tick();
    redirect = 1'b0;
    total++; if (if_pc !== 32'h3014 || imem_addr !== 32'h3100) begin
      bad++; $display("FAIL br_slot got=%h/%h exp=3014/3100", if_pc, imem_addr);
    end
    respond(1'b1);
    tick();
    total++; if (if_pc !== 32'h3100 || if_instr !== mem_word(32'h3100) || imem_addr !== 32'h3104) begin
      bad++; $display("FAIL br_target got=%h/%h exp=3100/3104", if_pc, imem_addr);
    end
  endtask

  task automatic test_pending();
    reach_branch();
    redirect = 1'b1; redirect_pc = 32'h3200; respond(1'b0);
    tick();
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'h3014) begin
      bad++; $display("FAIL pend_wait got=%b/%h exp=0/3014", if_valid, imem_addr);
    end
    respond(1'b1);
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h3014 || imem_addr !== 32'h3200) begin
      bad++; $display("FAIL pend_slot got=%b/%h/%h exp=1/3014/3200", if_valid, if_pc, imem_addr);
    end
    respond(1'b1);
    tick();
    total++; if (if_pc !== 32'h3200 || imem_addr !== 32'h3204) begin
      bad++; $display("FAIL pend_target got=%h/%h exp=3200/3204", if_pc, imem_addr);
    end
  endtask

  task automatic test_misalign();
    logic        exp_adel;
    logic [31:0] exp_addr;
`ifdef PC_ALIGN_CHECK_EN
    exp_adel = 1'b1; exp_addr = EXC_VEC;
`else
    exp_adel = 1'b0; exp_addr = 32'h3102;
`endif
    reach_branch();
    redirect = 1'b1; redirect_pc = 32'h3102; respond(1'b1);
    #1;
    total++; if (exc_adel !== exp_adel) begin bad++; $display("FAIL adel_pulse got=%b exp=%b", exc_adel, exp_adel); end
    tick();
    redirect = 1'b0;
    total++; if (imem_addr !== exp_addr || exc_adel !== 1'b0) begin
      bad++; $display("FAIL adel_next got=%h/%b exp=%h/0", imem_addr, exc_adel, exp_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    tick(); respond(1'b0);
    #2 reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", imem_req); end
    #2 reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hbad0_bad0;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL midrst_after got=%b/%b/%h exp=0/1/%h", if_valid, imem_req, imem_addr, RESET_PC);
    end
  endtask

  // Stream model: ID sees a PC sequence where a redirect taken while consuming word W
  // lets the next word (the delay slot) through and then continues at the target.
  task automatic test_random();
    logic [31:0] exp_next, exp_after, prev_addr, tgt;
    bit          prev_wait, stall, redir;
    int          idle, consumed;
    do_reset();
    exp_next  = RESET_PC;
    exp_after = RESET_PC + 32'd4;
    prev_wait = 1'b0;
    prev_addr = '0;
    idle      = 0;
    consumed  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (prev_wait && imem_req) begin
        total++; if (imem_addr !== prev_addr) begin
          bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, imem_addr, prev_addr);
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      redir = 1'b0;
      tgt   = RESET_PC + 32'($urandom_range(0, 255)) * 32'd4;
      if (if_valid && !stall) begin
        total++; if (if_pc !== exp_next || if_instr !== mem_word(exp_next) || if_pc8 !== exp_next + 32'd8) begin
          bad++; $display("FAIL rnd_deliver cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, if_pc, if_instr, if_pc8,
                          exp_next, mem_word(exp_next), exp_next + 32'd8);
        end
        redir    = ($urandom_range(0, 4) == 0);
        exp_next = exp_after;
        exp_after = redir ? tgt : exp_next + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
        if (stall) redir = $urandom_range(0, 1) == 1;
      end
      if (idle > 64) begin
        total++; bad++;
        $display("FAIL rnd_watchdog cyc=%0d got=no delivery exp=delivery within 64 cycles", cyc);
        break;
      end
      stall_id    = stall;
      redirect    = redir;
      redirect_pc = tgt;
      respond($urandom_range(0, 2) != 0);
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    stall_id = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    total++; if (consumed < 500) begin bad++; $display("FAIL rnd_progress got=%0d exp>=500", consumed); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_im_wait();
    test_stall_hold();
    test_branch();
    test_pending();
    test_misalign();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=still running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
